// File: rtl/fluxo_dados_jogo_param.sv
// Datapath for the memory-sequence game: address/limit counters, fixed ROM, switch register,
// switch edge detector and an optional inactivity watchdog (enabled by FLUXO_TIMEOUT_EN).
module fluxo_dados_jogo_param #(
  parameter int unsigned DATA_W         = 4,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              zeraE,
  input  logic              contaE,
  input  logic              zeraL,
  input  logic              contaL,
  input  logic              zeraR,
  input  logic              registraR,
  input  logic              zeraT,
  input  logic              contaT,
  input  logic [DATA_W-1:0] chaves,
  output logic              chavesIgualMemoria,
  output logic              fimE,
  output logic              fimL,
  output logic              enderecoIgualLimite,
  output logic              jogada_feita,
  output logic              timeout,
  output logic [ADDR_W-1:0] db_contagem,
  output logic [ADDR_W-1:0] db_limite,
  output logic [DATA_W-1:0] db_chaves,
  output logic [DATA_W-1:0] db_memoria
);

  logic [ADDR_W-1:0] e_q, e_d;
  logic [ADDR_W-1:0] l_q, l_d;
  logic [DATA_W-1:0] r_q, r_d;
  logic              chaves_hist_q, chaves_hist_d;
  logic              jogada_q, jogada_d;
  logic [DATA_W-1:0] rom_word;
  int unsigned       rom_sel;

  always_comb begin
    e_d = e_q;
    if (zeraE)       e_d = '0;
    else if (contaE) e_d = e_q + 1'b1;

    l_d = l_q;
    if (zeraL)       l_d = '0;
    else if (contaL) l_d = l_q + 1'b1;

    r_d = r_q;
    if (zeraR)          r_d = '0;
    else if (registraR) r_d = chaves;

    chaves_hist_d = |chaves;
    jogada_d      = (|chaves) & ~chaves_hist_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      e_q           <= '0;
      l_q           <= '0;
      r_q           <= '0;
      chaves_hist_q <= 1'b0;
      jogada_q      <= 1'b0;
    end else begin
      e_q           <= e_d;
      l_q           <= l_d;
      r_q           <= r_d;
      chaves_hist_q <= chaves_hist_d;
      jogada_q      <= jogada_d;
    end
  end

  // One-hot ROM word: bit (address mod DATA_W) set.
  always_comb begin
    rom_word = '0;
    rom_sel  = 32'(e_q) % DATA_W;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      rom_word[i] = (rom_sel == i);
    end
  end

`ifdef FLUXO_TIMEOUT_EN
  localparam int unsigned T_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [T_W-1:0] T_MAX = T_W'(TIMEOUT_CYCLES - 1);

  logic [T_W-1:0] t_q, t_d;

  always_comb begin
    t_d = t_q;
    if (zeraT)                        t_d = '0;
    else if (contaT && (t_q != T_MAX)) t_d = t_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) t_q <= '0;
    else        t_q <= t_d;
  end

  assign timeout = (t_q == T_MAX);
`else
  logic unused_watchdog_ctrl;
  assign unused_watchdog_ctrl = zeraT ^ contaT;
  assign timeout = 1'b0;
`endif

  assign chavesIgualMemoria  = (r_q == rom_word);
  assign fimE                = (e_q == '1);
  assign fimL                = (l_q == '1);
  assign enderecoIgualLimite = (e_q == l_q);
  assign jogada_feita        = jogada_q;
  assign db_contagem         = e_q;
  assign db_limite           = l_q;
  assign db_chaves           = r_q;
  assign db_memoria          = rom_word;

endmodule

// File: tb/tb_fluxo_dados_jogo_param.sv
// Directed bench for fluxo_dados_jogo_param (DATA_W=4, ADDR_W=4, TIMEOUT_CYCLES=8).
module tb_fluxo_dados_jogo_param;

  logic       clock = 1'b0;
  logic       reset;
  logic       zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT;
  logic [3:0] chaves;
  logic       chavesIgualMemoria, fimE, fimL, enderecoIgualLimite, jogada_feita, timeout;
  logic [3:0] db_contagem, db_limite, db_chaves, db_memoria;

  int checks   = 0;
  int failures = 0;

  fluxo_dados_jogo_param #(
    .DATA_W(4),
    .ADDR_W(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset),
    .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
    .zeraR(zeraR), .registraR(registraR), .zeraT(zeraT), .contaT(contaT),
    .chaves(chaves),
    .chavesIgualMemoria(chavesIgualMemoria), .fimE(fimE), .fimL(fimL),
    .enderecoIgualLimite(enderecoIgualLimite), .jogada_feita(jogada_feita),
    .timeout(timeout), .db_contagem(db_contagem), .db_limite(db_limite),
    .db_chaves(db_chaves), .db_memoria(db_memoria)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    zeraE = 0; contaE = 0; zeraL = 0; contaL = 0;
    zeraR = 0; registraR = 0; zeraT = 0; contaT = 0;
    chaves = 4'b0000;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    checks++; if (db_contagem !== 4'd0) begin failures++; $display("FAIL reset_E got=%0h exp=0", db_contagem); end
    checks++; if (db_limite !== 4'd0) begin failures++; $display("FAIL reset_L got=%0h exp=0", db_limite); end
    checks++; if (db_chaves !== 4'd0) begin failures++; $display("FAIL reset_R got=%0h exp=0", db_chaves); end
    checks++; if (db_memoria !== 4'b0001) begin failures++; $display("FAIL reset_mem got=%b exp=0001", db_memoria); end
    checks++; if (enderecoIgualLimite !== 1'b1) begin failures++; $display("FAIL reset_eil got=%b exp=1", enderecoIgualLimite); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    checks++; if ({fimE, fimL, jogada_feita} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {fimE, fimL, jogada_feita}); end
  endtask

  task automatic test_register();
    chaves = 4'b0001; registraR = 1;
    step();
    registraR = 0;
    checks++; if (db_chaves !== 4'b0001) begin failures++; $display("FAIL reg_load got=%b exp=0001", db_chaves); end
    checks++; if (chavesIgualMemoria !== 1'b1) begin failures++; $display("FAIL reg_match got=%b exp=1", chavesIgualMemoria); end
    contaE = 1;
    step();
    contaE = 0;
    checks++; if (db_memoria !== 4'b0010) begin failures++; $display("FAIL reg_mem1 got=%b exp=0010", db_memoria); end
    checks++; if (chavesIgualMemoria !== 1'b0) begin failures++; $display("FAIL reg_nomatch got=%b exp=0", chavesIgualMemoria); end
    chaves = 4'b1000; zeraR = 1; registraR = 1;
    step();
    zeraR = 0; registraR = 0; chaves = 4'b0000;
    checks++; if (db_chaves !== 4'b0000) begin failures++; $display("FAIL reg_zera_prio got=%b exp=0000", db_chaves); end
  endtask

  task automatic test_counter_e();
    zeraE = 1; step(); zeraE = 0;
    contaE = 1;
    for (int i = 1; i <= 15; i++) begin
      step();
      checks++; if (fimE !== (i == 15)) begin failures++; $display("FAIL fimE_%0d got=%b exp=%b", i, fimE, (i == 15)); end
    end
    checks++; if (db_contagem !== 4'd15) begin failures++; $display("FAIL E_at15 got=%0d exp=15", db_contagem); end
    step();
    checks++; if (db_contagem !== 4'd0 || fimE !== 1'b0) begin failures++; $display("FAIL E_wrap got=%0d/%b exp=0/0", db_contagem, fimE); end
    step(); step(); step();
    zeraE = 1;
    step();
    zeraE = 0; contaE = 0;
    checks++; if (db_contagem !== 4'd0) begin failures++; $display("FAIL E_zera_prio got=%0d exp=0", db_contagem); end
  endtask

  task automatic test_limit();
    zeraE = 1; zeraL = 1; step(); zeraE = 0; zeraL = 0;
    contaL = 1; step(); step(); contaL = 0;
    checks++; if (enderecoIgualLimite !== 1'b0) begin failures++; $display("FAIL eil_L2E0 got=%b exp=0", enderecoIgualLimite); end
    contaE = 1; step(); step(); contaE = 0;
    checks++; if (enderecoIgualLimite !== 1'b1) begin failures++; $display("FAIL eil_equal got=%b exp=1", enderecoIgualLimite); end
    contaE = 1; step(); contaE = 0;
    checks++; if (enderecoIgualLimite !== 1'b0) begin failures++; $display("FAIL eil_after got=%b exp=0", enderecoIgualLimite); end
    checks++; if (db_memoria !== 4'b1000) begin failures++; $display("FAIL mem_E3 got=%b exp=1000", db_memoria); end
    contaE = 1; step(); contaE = 0;
    checks++; if (db_memoria !== 4'b0001) begin failures++; $display("FAIL mem_E4 got=%b exp=0001", db_memoria); end
    contaL = 1;
    for (int i = 0; i < 13; i++) step();
    contaL = 0;
    checks++; if (db_limite !== 4'd15 || fimL !== 1'b1) begin failures++; $display("FAIL fimL got=%0d/%b exp=15/1", db_limite, fimL); end
    zeraL = 1; contaL = 1; step(); zeraL = 0; contaL = 0;
    checks++; if (db_limite !== 4'd0 || fimL !== 1'b0) begin failures++; $display("FAIL L_zera_prio got=%0d/%b exp=0/0", db_limite, fimL); end
  endtask

  task automatic test_edge();
    chaves = 4'b0000; step(); step();
    checks++; if (jogada_feita !== 1'b0) begin failures++; $display("FAIL edge_idle got=%b exp=0", jogada_feita); end
    chaves = 4'b0100;
    step();
    checks++; if (jogada_feita !== 1'b1) begin failures++; $display("FAIL edge_pulse1 got=%b exp=1", jogada_feita); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (jogada_feita !== 1'b0) begin failures++; $display("FAIL edge_hold_%0d got=%b exp=0", i, jogada_feita); end
    end
    chaves = 4'b0000; step();
    checks++; if (jogada_feita !== 1'b0) begin failures++; $display("FAIL edge_release got=%b exp=0", jogada_feita); end
    chaves = 4'b1000; step();
    checks++; if (jogada_feita !== 1'b1) begin failures++; $display("FAIL edge_pulse2 got=%b exp=1", jogada_feita); end
    step();
    checks++; if (jogada_feita !== 1'b0) begin failures++; $display("FAIL edge_pulse2_end got=%b exp=0", jogada_feita); end
    chaves = 4'b0000; step();
    chaves = 4'b0011; step();
    checks++; if (jogada_feita !== 1'b1) begin failures++; $display("FAIL edge_double got=%b exp=1", jogada_feita); end
    chaves = 4'b0001; step();
    checks++; if (jogada_feita !== 1'b0) begin failures++; $display("FAIL edge_double_end got=%b exp=0", jogada_feita); end
    chaves = 4'b0000; step();
  endtask

  task automatic test_timeout();
    idle_inputs();
    do_reset();
`ifdef FLUXO_TIMEOUT_EN
    contaT = 1;
    for (int i = 1; i <= 7; i++) begin
      step();
      checks++; if (timeout !== (i == 7)) begin failures++; $display("FAIL timeout_%0d got=%b exp=%b", i, timeout, (i == 7)); end
    end
    step(); step(); step();
    checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL timeout_sat got=%b exp=1", timeout); end
    zeraT = 1; step(); zeraT = 0;
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL timeout_zera got=%b exp=0", timeout); end
    step(); step(); step();
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      step();
      checks++; if (timeout !== (i == 7)) begin failures++; $display("FAIL timeout_rst_%0d got=%b exp=%b", i, timeout, (i == 7)); end
    end
    contaT = 0;
    zeraT = 1; step(); zeraT = 0;
`else
    contaT = 1;
    for (int i = 0; i < 10; i++) step();
    contaT = 0;
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL timeout_disabled got=%b exp=0", timeout); end
`endif
  endtask

  task automatic test_reset_mid();
    contaE = 1; contaL = 1; chaves = 4'b0010; registraR = 1;
    step(); step();
    contaE = 0; contaL = 0; registraR = 0; chaves = 4'b0000;
    checks++; if (db_contagem !== 4'd2 || db_limite !== 4'd2 || db_chaves !== 4'b0010) begin
      failures++; $display("FAIL mid_pre got=%0d/%0d/%b exp=2/2/0010", db_contagem, db_limite, db_chaves); end
    chaves = 4'b0100; contaE = 1;
    do_reset();
    contaE = 0;
    checks++; if (db_contagem !== 4'd0 || db_limite !== 4'd0 || db_chaves !== 4'd0) begin
      failures++; $display("FAIL mid_regs got=%0d/%0d/%b exp=0/0/0000", db_contagem, db_limite, db_chaves); end
    checks++; if (jogada_feita !== 1'b0 || db_memoria !== 4'b0001 || enderecoIgualLimite !== 1'b1) begin
      failures++; $display("FAIL mid_outs got=%b/%b/%b exp=0/0001/1", jogada_feita, db_memoria, enderecoIgualLimite); end
    step();
    checks++; if (jogada_feita !== 1'b1) begin failures++; $display("FAIL mid_hist_cleared got=%b exp=1", jogada_feita); end
    chaves = 4'b0000; step();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_register();
    test_counter_e();
    test_limit();
    test_edge();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
